// File: rtl/usb_line_pkg.sv
// Shared symbols, state encoding and FIFO entry type for the USB line transmitter.
// USB_LINE_LOW_SPEED_EN selects low-speed J/K polarity; SE0 is identical in both modes.
package usb_line_pkg;

`ifdef USB_LINE_LOW_SPEED_EN
    localparam logic [1:0] SYM_J = 2'b01;
    localparam logic [1:0] SYM_K = 2'b10;
`else
    localparam logic [1:0] SYM_J = 2'b10;
    localparam logic [1:0] SYM_K = 2'b01;
`endif
    localparam logic [1:0] SYM_SE0 = 2'b00;

    // Each state names the symbol class currently on the line.
    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        EOP_SE0,
        EOP_J
    } line_state_t;

    typedef struct packed {
        logic last;
        logic data;
    } entry_t;

    function automatic logic [1:0] bit_sym(input logic b);
        return b ? SYM_J : SYM_K;
    endfunction

endpackage

// File: rtl/line_tx_fifo.sv
// Small synchronous bit FIFO with flush; depth must be a power of two so pointers wrap naturally.
// any_last reports whether any buffered entry carries the packet-end marker.
module line_tx_fifo
    import usb_line_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  entry_t                   wr_entry,
    output entry_t                   rd_entry,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     any_last
);

    localparam int unsigned AW = $clog2(DEPTH);

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full && !flush;
    assign do_pop   = pop && !empty && !flush;
    assign rd_entry = mem[rd_ptr];

    always_comb begin
        any_last = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (((AW+1)'(i) < count) && mem[rd_ptr + AW'(i)].last)
                any_last = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wr_entry;
    end

endmodule

// File: rtl/usb_line_tx.sv
// USB D+/D- line transmitter: buffered bits out as J/K per bit_en, then SE0+J end-of-packet.
// USB_LINE_LOW_SPEED_EN (via usb_line_pkg) swaps J/K polarity for low-speed links.
module usb_line_tx
    import usb_line_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned START_LEVEL = 2,
    parameter int unsigned SE0_CYCLES  = 2,
    parameter int unsigned J_CYCLES    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bit_en,
    input  logic       tx_data,
    input  logic       tx_last,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       abort,
    output logic [1:0] dp_dm_out,
    output logic       oe,
    output logic       busy,
    output logic       sent_pkt,
    output logic       underrun
);

    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CMAX = (SE0_CYCLES > J_CYCLES) ? SE0_CYCLES : J_CYCLES;
    localparam int unsigned CW   = $clog2(CMAX + 1);

    line_state_t   state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [1:0]    line_nx;
    logic          oe_nx, sent_nx, underrun_nx;
    logic          drop, drop_nx;
    logic          last_drv, last_drv_nx;
    logic          pkt_err, pkt_err_nx;

    logic          flush, push, fifo_pop;
    logic          full, empty, any_last;
    entry_t        head, wr_entry;
    logic [AW:0]   fifo_count;

    assign flush    = bit_en && abort;
    assign tx_ready = !full && !flush;
    assign push     = tx_valid && tx_ready;
    assign busy     = (state != IDLE);
    assign wr_entry = '{last: tx_last, data: tx_data};

    line_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pop      (fifo_pop),
        .flush    (flush),
        .wr_entry (wr_entry),
        .rd_entry (head),
        .count    (fifo_count),
        .full     (full),
        .empty    (empty),
        .any_last (any_last)
    );

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        line_nx     = dp_dm_out;
        oe_nx       = oe;
        sent_nx     = 1'b0;
        underrun_nx = 1'b0;
        drop_nx     = drop;
        last_drv_nx = last_drv;
        pkt_err_nx  = pkt_err;
        fifo_pop    = 1'b0;

        case (state)
            IDLE: begin
                // Discarding the remainder of an underrun packet runs at clock rate, not bit rate.
                if (drop) begin
                    if (!empty && !flush) begin
                        fifo_pop = 1'b1;
                        if (head.last)
                            drop_nx = 1'b0;
                    end
                end else if (bit_en && !abort &&
                             ((fifo_count >= (AW+1)'(START_LEVEL)) || any_last)) begin
                    fifo_pop    = 1'b1;
                    line_nx     = bit_sym(head.data);
                    oe_nx       = 1'b1;
                    last_drv_nx = head.last;
                    state_nx    = DRIVE;
                end
            end

            DRIVE: begin
                if (bit_en) begin
                    if (abort) begin
                        line_nx    = SYM_SE0;
                        cnt_nx     = CW'(1);
                        pkt_err_nx = 1'b1;
                        state_nx   = EOP_SE0;
                    end else if (last_drv) begin
                        line_nx  = SYM_SE0;
                        cnt_nx   = CW'(1);
                        state_nx = EOP_SE0;
                    end else if (!empty) begin
                        fifo_pop    = 1'b1;
                        line_nx     = bit_sym(head.data);
                        last_drv_nx = head.last;
                    end else begin
                        underrun_nx = 1'b1;
                        line_nx     = SYM_SE0;
                        cnt_nx      = CW'(1);
                        drop_nx     = 1'b1;
                        pkt_err_nx  = 1'b1;
                        state_nx    = EOP_SE0;
                    end
                end
            end

            EOP_SE0: begin
                if (bit_en) begin
                    if (cnt == CW'(SE0_CYCLES)) begin
                        line_nx  = SYM_J;
                        cnt_nx   = CW'(1);
                        state_nx = EOP_J;
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end
            end

            EOP_J: begin
                if (bit_en) begin
                    if (cnt == CW'(J_CYCLES)) begin
                        line_nx    = SYM_J;
                        oe_nx      = 1'b0;
                        sent_nx    = !pkt_err;
                        pkt_err_nx = 1'b0;
                        state_nx   = IDLE;
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end
            end

            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            dp_dm_out <= SYM_J;
            oe        <= 1'b0;
            sent_pkt  <= 1'b0;
            underrun  <= 1'b0;
            drop      <= 1'b0;
            last_drv  <= 1'b0;
            pkt_err   <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            dp_dm_out <= line_nx;
            oe        <= oe_nx;
            sent_pkt  <= sent_nx;
            underrun  <= underrun_nx;
            drop      <= drop_nx;
            last_drv  <= last_drv_nx;
            pkt_err   <= pkt_err_nx;
        end
    end

endmodule
